// File: rtl/cart_seq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cart_seq_pkg                                               |
// | Description : Shared state enum, default phase timing and phase-counter  |
// |               width for the cartridge port sequencer.                    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package cart_seq_pkg;

   localparam int unsigned c_def_setup_cycles  = 1;
   localparam int unsigned c_def_strobe_cycles = 2;
   localparam int unsigned c_def_hold_cycles   = 1;
   localparam int unsigned c_def_turn_cycles   = 1;
   localparam int unsigned c_cnt_w             = 4;

   typedef logic [c_cnt_w-1:0] cnt_t;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SETUP  = 3'd1,
      ST_STROBE = 3'd2,
      ST_HOLD   = 3'd3,
      ST_TURN   = 3'd4
   } seq_state_t;

   // Phases count down from length-1 to 0, so a 1..15 length always fits.
   function automatic cnt_t phase_load(input int unsigned cycles);
      return cnt_t'(cycles - 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/cart_port_sequencer_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cart_port_sequencer_if                                     |
// | Description : Request/response handshake and cartridge port pins of the  |
// |               sequencer. slave = sequencer side, master = requester/pins.|
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
interface cart_port_sequencer_if;
   logic       req_valid;
   logic       req_ready;
   logic       req_write;
   logic [7:0] req_data;
   logic       dir_to_port;
   logic [7:0] to_port;
   logic [7:0] from_port;
   logic       port_strobe;
   logic       rsp_valid;
   logic [7:0] rsp_data;

   modport slave (
      input  req_valid, req_write, req_data, from_port,
      output req_ready, dir_to_port, to_port, port_strobe, rsp_valid, rsp_data
   );

   modport master (
      output req_valid, req_write, req_data, from_port,
      input  req_ready, dir_to_port, to_port, port_strobe, rsp_valid, rsp_data
   );
endinterface
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : sync_2ff                                                   |
// | Description : Two-flop synchronizer for the asynchronous port read bus;  |
// |               only present in builds with CART_SEQ_SYNC_EN defined.      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
`ifdef CART_SEQ_SYNC_EN
module sync_2ff #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);
   logic [WIDTH-1:0] r_meta;
   logic [WIDTH-1:0] r_sync;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_meta <= '0;
         r_sync <= '0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;
endmodule
`endif
`default_nettype wire

// File: rtl/cart_port_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : cart_port_sequencer                                        |
// | Description : Setup/strobe/hold/turnaround sequencer for an 8-bit        |
// |               cartridge port. CART_SEQ_SYNC_EN adds a from_port          |
// |               synchronizer and stretches STROBE by two cycles.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module cart_port_sequencer
   import cart_seq_pkg::*;
#(
   parameter int unsigned SETUP_CYCLES  = c_def_setup_cycles,
   parameter int unsigned STROBE_CYCLES = c_def_strobe_cycles,
   parameter int unsigned HOLD_CYCLES   = c_def_hold_cycles,
   parameter int unsigned TURN_CYCLES   = c_def_turn_cycles
) (
   input  logic                  clk,
   input  logic                  reset,
   cart_port_sequencer_if.slave  bus
);

   logic [7:0] w_sample_src;

`ifdef CART_SEQ_SYNC_EN
   // Extra strobe cycles let the port value settle through the synchronizer.
   localparam logic [1:0] c_strobe_ext = 2'd2;

   sync_2ff #(
      .WIDTH (8)
   ) u_sync (
      .clk   (clk),
      .reset (reset),
      .i_d   (bus.from_port),
      .o_q   (w_sample_src)
   );
`else
   localparam logic [1:0] c_strobe_ext = 2'd0;

   assign w_sample_src = bus.from_port;
`endif

   seq_state_t r_state;
   cnt_t       r_cnt;
   logic [1:0] r_ext;
   logic       r_write;
   logic       r_ready;
   logic       r_dir;
   logic [7:0] r_to_port;
   logic       r_strobe;
   logic       r_rsp_valid;
   logic [7:0] r_rsp_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_ext       <= '0;
         r_write     <= 1'b0;
         r_ready     <= 1'b0;
         r_dir       <= 1'b0;
         r_to_port   <= 8'h00;
         r_strobe    <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_data  <= 8'h00;
      end else begin
         r_rsp_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               r_ready <= 1'b1;
               if (bus.req_valid && r_ready) begin
                  r_ready   <= 1'b0;
                  r_write   <= bus.req_write;
                  r_dir     <= bus.req_write;
                  r_to_port <= bus.req_data;
                  r_cnt     <= phase_load(SETUP_CYCLES);
                  r_state   <= ST_SETUP;
               end
            end

            ST_SETUP: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_cnt    <= phase_load(STROBE_CYCLES);
                  r_ext    <= c_strobe_ext;
                  r_strobe <= 1'b1;
                  r_state  <= ST_STROBE;
               end
            end

            ST_STROBE: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else if (r_ext != 2'd0) begin
                  r_ext <= r_ext - 1'b1;
               end else begin
                  // Last strobe edge: the port value is captured here.
                  if (!r_write) begin
                     r_rsp_data <= w_sample_src;
                  end
                  r_strobe <= 1'b0;
                  r_cnt    <= phase_load(HOLD_CYCLES);
                  r_state  <= ST_HOLD;
               end
            end

            ST_HOLD: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_dir     <= 1'b0;
                  r_to_port <= 8'h00;
                  if (r_write) begin
                     r_cnt   <= phase_load(TURN_CYCLES);
                     r_state <= ST_TURN;
                  end else begin
                     r_ready     <= 1'b1;
                     r_rsp_valid <= 1'b1;
                     r_state     <= ST_IDLE;
                  end
               end
            end

            ST_TURN: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_ready     <= 1'b1;
                  r_rsp_valid <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end

            default: begin
               r_cnt    <= '0;
               r_ext    <= '0;
               r_dir    <= 1'b0;
               r_strobe <= 1'b0;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready   = r_ready;
   assign bus.dir_to_port = r_dir;
   assign bus.to_port     = r_to_port;
   assign bus.port_strobe = r_strobe;
   assign bus.rsp_valid   = r_rsp_valid;
   assign bus.rsp_data    = r_rsp_data;

endmodule
`default_nettype wire

// File: tb/tb_cart_port_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_cart_port_sequencer                                     |
// | Description : Random + directed bench with a transaction-level timeline  |
// |               model; honours CART_SEQ_SYNC_EN.                           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_cart_port_sequencer;

`ifdef CART_SEQ_SYNC_EN
   localparam int c_ext    = 2;
   localparam int c_slat   = 2;
   localparam int c_rd_lat = 7;
   localparam int c_wr_lat = 8;
   localparam int c_stb    = 4;
   localparam int c_wr_dir = 6;
   localparam int c_b_stb  = 17;
   localparam int c_b_lat  = 63;
`else
   localparam int c_ext    = 0;
   localparam int c_slat   = 0;
   localparam int c_rd_lat = 5;
   localparam int c_wr_lat = 6;
   localparam int c_stb    = 2;
   localparam int c_wr_dir = 4;
   localparam int c_b_stb  = 15;
   localparam int c_b_lat  = 61;
`endif
   localparam int c_s = 1;
   localparam int c_t = 2;
   localparam int c_h = 1;
   localparam int c_u = 1;

   typedef struct packed {
      logic       ready;
      logic       dir;
      logic [7:0] to;
      logic       strobe;
      logic       rv;
   } obs_t;

   typedef struct {
      obs_t o;
      int   samp;
   } ent_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   int   n_checks = 0;
   int   n_pass   = 0;
   ent_t exp_q[$];
   logic [7:0] fp_hist[int];
   int   cyc      = 0;
   bit   model_en = 1'b0;
   bit   fresh    = 1'b0;

   always #5 clk = ~clk;

   cart_port_sequencer_if bus_a();
   cart_port_sequencer_if bus_b();

   cart_port_sequencer dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a.slave)
   );

   cart_port_sequencer #(
      .SETUP_CYCLES  (15),
      .STROBE_CYCLES (15),
      .HOLD_CYCLES   (15),
      .TURN_CYCLES   (15)
   ) dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b.slave)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // Expected per-cycle outputs of one transaction accepted in cycle c.
   function automatic void push_txn(input logic w, input logic [7:0] d, input int c);
      ent_t e;
      e.samp     = -1;
      e.o        = '0;
      e.o.dir    = w;
      e.o.to     = d;
      for (int i = 0; i < c_s; i++) exp_q.push_back(e);
      e.o.strobe = 1'b1;
      for (int i = 0; i < c_t + c_ext; i++) exp_q.push_back(e);
      e.o.strobe = 1'b0;
      for (int i = 0; i < c_h; i++) exp_q.push_back(e);
      if (w) begin
         e.o.dir = 1'b0;
         e.o.to  = 8'h00;
         for (int i = 0; i < c_u; i++) exp_q.push_back(e);
      end
      e.o       = '0;
      e.o.ready = 1'b1;
      e.o.rv    = 1'b1;
      e.samp    = w ? -1 : c + c_s + c_t + c_ext - c_slat;
      exp_q.push_back(e);
   endfunction

   always @(negedge clk) begin
      if (model_en) begin
         ent_t e;
         obs_t act;
         fp_hist[cyc] = bus_a.from_port;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
         end else begin
            e.o       = '0;
            e.o.ready = !fresh;
            e.samp    = -1;
         end
         fresh      = 1'b0;
         act.ready  = bus_a.req_ready;
         act.dir    = bus_a.dir_to_port;
         act.to     = bus_a.to_port;
         act.strobe = bus_a.port_strobe;
         act.rv     = bus_a.rsp_valid;
         check($sformatf("cycle %0d {ready,dir,to,strobe,rsp_valid}", cyc), {20'd0, act}, {20'd0, e.o});
         if (e.samp >= 0)
            check($sformatf("cycle %0d rsp_data", cyc), {24'd0, bus_a.rsp_data}, {24'd0, fp_hist[e.samp]});
         if (e.o.ready && bus_a.req_valid)
            push_txn(bus_a.req_write, bus_a.req_data, cyc);
         cyc++;
      end
   end

   task automatic release_model();
      exp_q.delete();
      fresh    = 1'b1;
      model_en = 1'b1;
   endtask

   task automatic wait_ready();
      int k = 0;
      while (!bus_a.req_ready && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      check("req_ready wait", {31'd0, bus_a.req_ready}, 32'd1);
   endtask

   task automatic directed(input logic w, input logic [7:0] d, input logic [7:0] fp,
                           output int lat, output int nstb, output int ndir1,
                           output int ngood, output int nd0, output logic [7:0] rd);
      bus_a.from_port = fp;
      bus_a.req_write = w;
      bus_a.req_data  = d;
      bus_a.req_valid = 1'b1;
      wait_ready();
      @(posedge clk); #1;
      bus_a.req_valid = 1'b0;
      bus_a.req_write = ~w;
      bus_a.req_data  = ~d;
      lat = 1; nstb = 0; ndir1 = 0; ngood = 0; nd0 = 0;
      while (!bus_a.rsp_valid && lat < 100) begin
         if (bus_a.port_strobe) nstb++;
         if (bus_a.dir_to_port) ndir1++;
         else nd0++;
         if (bus_a.dir_to_port && bus_a.to_port == d) ngood++;
         @(posedge clk); #1;
         lat++;
      end
      rd = bus_a.rsp_data;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, nstb, ndir1, ngood, nd0, nturn, nset, nhold, nrv, k;
      logic [7:0] rd;
      logic [31:0] m_ready, m_rv;

      bus_a.req_valid = 1'b0; bus_a.req_write = 1'b0; bus_a.req_data = 8'h00; bus_a.from_port = 8'h00;
      bus_b.req_valid = 1'b0; bus_b.req_write = 1'b0; bus_b.req_data = 8'h00; bus_b.from_port = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      check("reset req_ready",   {31'd0, bus_a.req_ready},   32'd0);
      check("reset dir_to_port", {31'd0, bus_a.dir_to_port}, 32'd0);
      check("reset port_strobe", {31'd0, bus_a.port_strobe}, 32'd0);
      check("reset to_port",     {24'd0, bus_a.to_port},     32'd0);
      check("reset rsp_valid",   {31'd0, bus_a.rsp_valid},   32'd0);
      check("reset rsp_data",    {24'd0, bus_a.rsp_data},    32'd0);
      reset = 1'b0;
      release_model();
      @(posedge clk); #1;
      check("req_ready after first edge", {31'd0, bus_a.req_ready}, 32'd1);

      // Read with A5 held on the port.
      directed(1'b0, 8'h11, 8'hA5, lat, nstb, ndir1, ngood, nd0, rd);
      check("read latency",     lat,   c_rd_lat);
      check("read strobe len",  nstb,  c_stb);
      check("read dir_to_port", ndir1, 0);
      check("read rsp_data",    {24'd0, rd}, 32'hA5);

      // Write 3C.
      directed(1'b1, 8'h3C, 8'h77, lat, nstb, ndir1, ngood, nd0, rd);
      check("write latency",       lat,   c_wr_lat);
      check("write strobe len",    nstb,  c_stb);
      check("write drive cycles",  ndir1, c_wr_dir);
      check("write to_port=3C",    ngood, c_wr_dir);
      check("write turn cycles",   nd0,   1);

      // Back-to-back: req_valid held, write then read.
      wait_ready();
      bus_a.req_valid = 1'b1;
      bus_a.req_write = 1'b1;
      bus_a.req_data  = 8'h5C;
      @(posedge clk); #1;
      bus_a.req_write = 1'b0;
      m_ready = '0;
      m_rv    = '0;
      for (int i = 1; i <= c_wr_lat + c_rd_lat; i++) begin
         if (bus_a.req_ready) m_ready[i] = 1'b1;
         if (bus_a.rsp_valid) m_rv[i]    = 1'b1;
         if (i < c_wr_lat + c_rd_lat) begin
            @(posedge clk); #1;
         end
      end
      bus_a.req_valid = 1'b0;
      check("b2b req_ready cycles", m_ready, (32'd1 << c_wr_lat) | (32'd1 << (c_wr_lat + c_rd_lat)));
      check("b2b rsp_valid cycles", m_rv,    (32'd1 << c_wr_lat) | (32'd1 << (c_wr_lat + c_rd_lat)));

      // Random traffic with a changing port value every cycle.
      for (int i = 0; i < 800; i++) begin
         @(posedge clk); #1;
         bus_a.req_valid = ($urandom_range(0, 3) != 0);
         bus_a.req_write = 1'($urandom_range(0, 1));
         bus_a.req_data  = 8'($urandom);
         bus_a.from_port = 8'($urandom);
      end
      bus_a.req_valid = 1'b0;

      // Reset in the middle of a write strobe.
      wait_ready();
      bus_a.req_valid = 1'b1;
      bus_a.req_write = 1'b1;
      bus_a.req_data  = 8'hC3;
      @(posedge clk); #1;
      bus_a.req_valid = 1'b0;
      k = 0;
      while (!bus_a.port_strobe && k < 20) begin
         @(posedge clk); #1;
         k++;
      end
      check("strobe reached before reset", {31'd0, bus_a.port_strobe}, 32'd1);
      #1;
      model_en = 1'b0;
      reset    = 1'b1;
      #1;
      check("async reset dir_to_port", {31'd0, bus_a.dir_to_port}, 32'd0);
      check("async reset port_strobe", {31'd0, bus_a.port_strobe}, 32'd0);
      check("async reset to_port",     {24'd0, bus_a.to_port},     32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      release_model();
      nrv = 0;
      repeat (12) begin
         @(posedge clk); #1;
         if (bus_a.rsp_valid) nrv++;
      end
      check("no rsp_valid after reset", nrv, 0);

      // All phases at 15 on the second instance.
      bus_b.req_valid = 1'b1;
      bus_b.req_write = 1'b1;
      bus_b.req_data  = 8'h96;
      k = 0;
      while (!bus_b.req_ready && k < 100) begin
         @(posedge clk); #1;
         k++;
      end
      check("long req_ready wait", {31'd0, bus_b.req_ready}, 32'd1);
      @(posedge clk); #1;
      bus_b.req_valid = 1'b0;
      lat = 1; nset = 0; nstb = 0; nhold = 0; nturn = 0;
      while (!bus_b.rsp_valid && lat < 200) begin
         if (bus_b.port_strobe) nstb++;
         else if (bus_b.dir_to_port && nstb == 0) nset++;
         else if (bus_b.dir_to_port) nhold++;
         else nturn++;
         @(posedge clk); #1;
         lat++;
      end
      check("long setup len",  nset,  15);
      check("long strobe len", nstb,  c_b_stb);
      check("long hold len",   nhold, 15);
      check("long turn len",   nturn, 15);
      check("long latency",    lat,   c_b_lat);

      repeat (3) @(posedge clk);
      #1;
      model_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
